// File: rtl/lc3b_muldiv_pkg.sv
// lc3b_muldiv_pkg: shared types for the LC-3b multiply/divide slice.
//   lc3b_word          - 16-bit datapath word
//   lc3b_aluop         - ALU operation field of the ID/EX control word
//   lc3b_muldiv_state  - FSM state of the iterative mult/div unit
//   MULDIV_ITER        - number of shift-add / restoring-divide iterations
//   mag16()            - two's complement magnitude of a word
package lc3b_muldiv_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    alu_add,
    alu_and,
    alu_not,
    alu_pass,
    alu_sll,
    alu_srl,
    alu_sra,
    alu_mult,
    alu_div
  } lc3b_aluop;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } lc3b_muldiv_state;

  localparam int MULDIV_ITER = 16;

  // Magnitude of a signed word. -32768 maps to 16'h8000, which is
  // still the correct unsigned magnitude.
  function automatic lc3b_word mag16(input lc3b_word v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/lc3b_muldiv_control.sv
// lc3b_muldiv_control: sequencing for the iterative mult/div unit.
//   clk, reset_n  - clock, asynchronous active-low reset
//   start, aluop  - request from the EX stage
//   b_zero        - divisor operand is zero
//   flush         - aborts any operation, returns to IDLE
//   busy          - combinational stall request to the hazard unit
//   done          - registered one-cycle completion pulse
//   accept        - request taken this cycle (datapath latches operands)
//   accept_dz     - request taken and it is a divide by zero
//   state         - current FSM state (also used by the datapath)
// Handshake: a request is taken when state is IDLE, start is high, aluop
// is mult/div and flush is low; busy then stays high until the DONE
// cycle, on whose closing edge the pipeline captures the result.
module lc3b_muldiv_control
  import lc3b_muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  lc3b_aluop        aluop,
  input  logic             b_zero,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             accept,
  output logic             accept_dz,
  output lc3b_muldiv_state state
);

  logic [3:0] count;
  logic       op_ok;

  assign op_ok     = start && ((aluop == alu_mult) || (aluop == alu_div));
  assign accept    = (state == IDLE) && op_ok && !flush;
  assign accept_dz = accept && (aluop == alu_div) && b_zero;
  // Low in DONE so the pipeline advances and takes the result.
  assign busy      = (state == CALC) || (state == FIX) || accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= 4'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept_dz) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (accept) begin
              state <= CALC;
              count <= 4'(MULDIV_ITER - 1);
            end
          end
          CALC: begin
            if (count == 4'd0) state <= FIX;
            else               count <= count - 4'd1;
          end
          FIX: begin
            state <= DONE;
            done  <= 1'b1;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/lc3b_muldiv.sv
// lc3b_muldiv: iterative signed 16x16 multiply / 16/16 divide for EX.
//   clk, reset_n - clock, asynchronous active-low reset
//   start, aluop - EX holds a mult/div instruction
//   a, b         - dividend/multiplicand, divisor/multiplier
//   flush        - abort, no done pulse, outputs untouched
//   busy         - stall request (combinational)
//   done         - one-cycle pulse, result valid
//   result       - low product word or quotient
//   div_by_zero  - qualifies done: divisor was zero
//   result_hi    - high product word or remainder; only when the
//                  LC3B_MULDIV_HI_EN macro is defined
module lc3b_muldiv
  import lc3b_muldiv_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      start,
  input  lc3b_aluop aluop,
  input  lc3b_word  a,
  input  lc3b_word  b,
  input  logic      flush,
  output logic      busy,
  output logic      done,
  output lc3b_word  result,
  output logic      div_by_zero
`ifdef LC3B_MULDIV_HI_EN
  ,
  output lc3b_word  result_hi
`endif
);

  lc3b_muldiv_state state;
  logic             accept;
  logic             accept_dz;
  logic             load_fix;

  // Multiply: acc = {partial product, multiplier}, mag_x = multiplicand.
  // Divide:   acc = {remainder, dividend/quotient}, mag_x = divisor.
  logic [31:0] acc;
  logic [31:0] next_acc;
  lc3b_word    mag_x;
  logic        is_div;
  logic        neg_q;
  logic [16:0] mul_sum;
  logic [16:0] div_trial;
  lc3b_word    fix_lo;

  lc3b_muldiv_control u_control (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .aluop     (aluop),
    .b_zero    (b == 16'd0),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .accept    (accept),
    .accept_dz (accept_dz),
    .state     (state)
  );

  assign mul_sum   = {1'b0, acc[31:16]} + {1'b0, (acc[0] ? mag_x : 16'd0)};
  // The remainder stays below the divisor (<= 16'h8000), so acc[31]
  // is always clear during a divide and the shifted-in top is acc[30:15].
  assign div_trial = {1'b0, acc[30:15]} - {1'b0, mag_x};

  always_comb begin
    next_acc = {mul_sum, acc[15:1]};
    if (is_div) begin
      if (div_trial[16]) next_acc = {acc[30:0], 1'b0};
      else               next_acc = {div_trial[15:0], acc[14:0], 1'b1};
    end
  end

  // Low word of a negated product equals the negated low word, so the
  // same fix-up serves quotient and product.
  assign fix_lo   = neg_q ? (~acc[15:0] + 16'd1) : acc[15:0];
  assign load_fix = (state == FIX) && !flush;

`ifdef LC3B_MULDIV_HI_EN
  logic     neg_r;
  lc3b_word fix_hi;

  always_comb begin
    fix_hi = acc[31:16];
    if (is_div) begin
      if (neg_r) fix_hi = ~acc[31:16] + 16'd1;
    end else if (neg_q) begin
      // High word of a 32-bit negation: carry in only when low word is 0.
      fix_hi = ~acc[31:16] + {15'd0, (acc[15:0] == 16'd0)};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg_r     <= 1'b0;
      result_hi <= 16'd0;
    end else begin
      if (accept) neg_r <= a[15];
      if (accept_dz)     result_hi <= a;
      else if (load_fix) result_hi <= fix_hi;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= 32'd0;
      mag_x       <= 16'd0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      result      <= 16'd0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        is_div <= (aluop == alu_div);
        neg_q  <= a[15] ^ b[15];
        if (aluop == alu_div) begin
          acc   <= {16'd0, mag16(a)};
          mag_x <= mag16(b);
        end else begin
          acc   <= {16'd0, mag16(b)};
          mag_x <= mag16(a);
        end
      end else if (state == CALC) begin
        acc <= next_acc;
      end

      if (accept_dz) begin
        result      <= 16'hFFFF;
        div_by_zero <= 1'b1;
      end else if (load_fix) begin
        result      <= fix_lo;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lc3b_muldiv.sv
// tb_lc3b_muldiv: directed-vector bench for lc3b_muldiv.
// Define LC3B_MULDIV_HI_EN for both RTL and bench to cover result_hi.
module tb_lc3b_muldiv;
  import lc3b_muldiv_pkg::*;

  // ---------------- clock / reset ----------------
  logic      clk = 1'b0;
  logic      reset_n = 1'b0;
  logic      start = 1'b0;
  lc3b_aluop aluop = alu_add;
  lc3b_word  a = 16'd0;
  lc3b_word  b = 16'd0;
  logic      flush = 1'b0;
  logic      busy;
  logic      done;
  lc3b_word  result;
  logic      div_by_zero;
`ifdef LC3B_MULDIV_HI_EN
  lc3b_word  result_hi;
`endif

  always #5 clk = ~clk;

  lc3b_muldiv dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .aluop       (aluop),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
`ifdef LC3B_MULDIV_HI_EN
    ,
    .result_hi   (result_hi)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issues one request and follows it to the done pulse. exp_lat is the
  // number of cycles from the accept cycle to the done cycle; every cycle
  // before done is a stall, so the busy count equals exp_lat.
  task automatic run_op(input string tag, input lc3b_aluop op,
                        input lc3b_word av, input lc3b_word bv,
                        input int exp_lat, input lc3b_word exp_res,
                        input lc3b_word exp_hi, input logic exp_dz);
    int   lat;
    int   nbusy;
    logic seen;
    @(negedge clk);
    start = 1'b1;
    aluop = op;
    a     = av;
    b     = bv;
    #1;
    check_eq({tag, " accept_busy"}, 32'(busy), 32'd1);
    nbusy = 1;
    lat   = 0;
    seen  = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen  = 1'b1;
        lat   = k;
        start = 1'b0;
        check_eq({tag, " done_busy"}, 32'(busy), 32'd0);
      end else if (busy) begin
        nbusy++;
      end
    end
    check_eq({tag, " done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " stall_cycles"}, 32'(nbusy), 32'(exp_lat));
    check_eq({tag, " result"}, 32'(result), 32'(exp_res));
    check_eq({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp_dz));
`ifdef LC3B_MULDIV_HI_EN
    check_eq({tag, " result_hi"}, 32'(result_hi), 32'(exp_hi));
`else
    if (exp_hi !== exp_hi) $display("unreachable");
`endif
    start = 1'b0;
    @(negedge clk);
    #1;
    check_eq({tag, " done_pulse_1cyc"}, 32'(done), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic done_seen;

  initial begin
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst result", 32'(result), 32'd0);
    check_eq("rst div_by_zero", 32'(div_by_zero), 32'd0);
    check_eq("rst state", 32'(dut.u_control.state), 32'(IDLE));
`ifdef LC3B_MULDIV_HI_EN
    check_eq("rst result_hi", 32'(result_hi), 32'd0);
`endif
    reset_n = 1'b1;

    // tag, op, a, b, latency, result, result_hi, div_by_zero
    run_op("mul 7x-3",       alu_mult, 16'd7,     16'hFFFD, 18, 16'hFFEB, 16'hFFFF, 1'b0);
    run_op("div -7/2",       alu_div,  16'hFFF9,  16'd2,    18, 16'hFFFD, 16'hFFFF, 1'b0);
    run_op("div 100/0",      alu_div,  16'd100,   16'd0,    1,  16'hFFFF, 16'h0064, 1'b1);
    run_op("mul 7fff^2",     alu_mult, 16'h7FFF,  16'h7FFF, 18, 16'h0001, 16'h3FFF, 1'b0);
    run_op("div 8000/ffff",  alu_div,  16'h8000,  16'hFFFF, 18, 16'h8000, 16'h0000, 1'b0);
    run_op("mul 8000x8000",  alu_mult, 16'h8000,  16'h8000, 18, 16'h0000, 16'h4000, 1'b0);
    run_op("mul 0x-5",       alu_mult, 16'd0,     16'hFFFB, 18, 16'h0000, 16'h0000, 1'b0);
    run_op("div 7/-2",       alu_div,  16'd7,     16'hFFFE, 18, 16'hFFFD, 16'h0001, 1'b0);

    // Flush in CALC cycle 5: abort, no done, result keeps 16'hFFFD.
    @(negedge clk);
    start = 1'b1;
    aluop = alu_mult;
    a     = 16'd5;
    b     = 16'd6;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_eq("flush busy_next", 32'(busy), 32'd0);
    check_eq("flush state_idle", 32'(dut.u_control.state), 32'(IDLE));
    done_seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      #1;
      if (done) done_seen = 1'b1;
    end
    check_eq("flush no_done", 32'(done_seen), 32'd0);
    check_eq("flush result_kept", 32'(result), 32'hFFFD);

    run_op("mul 3x4", alu_mult, 16'd3, 16'd4, 18, 16'd12, 16'd0, 1'b0);

    // flush wins over an accept in the same cycle
    @(negedge clk);
    start = 1'b1;
    aluop = alu_div;
    a     = 16'd9;
    b     = 16'd3;
    flush = 1'b1;
    #1;
    check_eq("flush_vs_accept busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1;
    check_eq("flush_vs_accept state", 32'(dut.u_control.state), 32'(IDLE));

    // non-mult/div op is ignored
    @(negedge clk);
    start = 1'b1;
    aluop = alu_add;
    a     = 16'd1;
    b     = 16'd2;
    #1;
    check_eq("add busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check_eq("add state", 32'(dut.u_control.state), 32'(IDLE));
    check_eq("add done", 32'(done), 32'd0);
    check_eq("add result", 32'(result), 32'd12);
    start = 1'b0;

    // reset mid-CALC clears outputs immediately
    @(negedge clk);
    start = 1'b1;
    aluop = alu_mult;
    a     = 16'd9;
    b     = 16'd9;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    check_eq("midrst busy", 32'(busy), 32'd0);
    check_eq("midrst done", 32'(done), 32'd0);
    check_eq("midrst result", 32'(result), 32'd0);
    check_eq("midrst div_by_zero", 32'(div_by_zero), 32'd0);
`ifdef LC3B_MULDIV_HI_EN
    check_eq("midrst result_hi", 32'(result_hi), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("midrst state_idle", 32'(dut.u_control.state), 32'(IDLE));
    check_eq("midrst busy_after", 32'(busy), 32'd0);

    run_op("mul -1x-1", alu_mult, 16'hFFFF, 16'hFFFF, 18, 16'h0001, 16'h0000, 1'b0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
